// File: rtl/alu_spi_responder.sv
// Purpose : SPI-style serial responder; receives {B, A, op} LSB first, runs one ALU op, returns the result.
// Latency : 1 + P + 1 + 1 + DATA_WIDTH cycles from start-bit edge to IDLE, P = OP_WIDTH + 2*DATA_WIDTH (30 at defaults).
// Backpressure: none; the initiator paces every bit, and releasing i_nss aborts the exchange with no response.
//
// Ports:
//   i_clock  - system clock, also the serial bit clock (rising edge)
//   i_reset  - asynchronous active-high reset
//   i_nss    - slave select, active-low
//   i_mosi   - serial request: start bit '1', then op, A, B, each LSB first
//   o_miso   - registered serial response: start bit '1', then result LSB first
//   o_busy   - high whenever the machine is not in IDLE
module alu_spi_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 3
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_nss,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_busy
);

  localparam int PKT_W = OP_WIDTH + 2 * DATA_WIDTH;
  localparam int CNT_W = (PKT_W > 1) ? $clog2(PKT_W) : 1;
  localparam int SH_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    COMPUTE,
    TX_START,
    TX
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [PKT_W-1:0]      packet;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] alu_res;

  logic [OP_WIDTH-1:0]   op;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [SH_W-1:0]       shamt;
  logic [SH_W-1:0]       tx_idx;

  assign op    = packet[OP_WIDTH-1:0];
  assign op_a  = packet[OP_WIDTH +: DATA_WIDTH];
  assign op_b  = packet[OP_WIDTH + DATA_WIDTH +: DATA_WIDTH];
  // Shift amount uses only the bits needed to address a bit of the operand.
  assign shamt = op_b[SH_W-1:0];

  // o_miso is registered, so each TX edge loads the bit for the *next* cycle.
  assign tx_idx = SH_W'(cnt + CNT_W'(1));

  assign o_busy = (state != IDLE);

  // Arithmetic wraps naturally at DATA_WIDTH; unused op codes give zero.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_WIDTH'(0): alu_res = op_a + op_b;
      OP_WIDTH'(1): alu_res = op_a - op_b;
      OP_WIDTH'(2): alu_res = op_a & op_b;
      OP_WIDTH'(3): alu_res = op_a | op_b;
      OP_WIDTH'(4): alu_res = op_a ^ op_b;
      OP_WIDTH'(5): alu_res = op_a << shamt;
      OP_WIDTH'(6): alu_res = op_a >> shamt;
      OP_WIDTH'(7): alu_res = op_a;
      default:      alu_res = '0;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      cnt    <= '0;
      packet <= '0;
      result <= '0;
      o_miso <= 1'b0;
    end else if (state == IDLE) begin
      o_miso <= 1'b0;
      cnt    <= '0;
      if (!i_nss && i_mosi) begin
        state <= RX;
      end
    end else if (i_nss) begin
      // Deselect mid-exchange: drop everything, nothing is sent back.
      state  <= IDLE;
      cnt    <= '0;
      packet <= '0;
      result <= '0;
      o_miso <= 1'b0;
    end else begin
      case (state)
        RX: begin
          o_miso      <= 1'b0;
          packet[cnt] <= i_mosi;
          if (cnt == CNT_W'(PKT_W - 1)) begin
            cnt   <= '0;
            state <= COMPUTE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        COMPUTE: begin
          result <= alu_res;
          o_miso <= 1'b1;   // response start bit shows during TX_START
          state  <= TX_START;
        end
        TX_START: begin
          o_miso <= result[0];
          cnt    <= '0;
          state  <= TX;
        end
        TX: begin
          if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
            o_miso <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            o_miso <= result[tx_idx];
            cnt    <= cnt + CNT_W'(1);
          end
        end
        default: begin
          o_miso <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_spi_responder.sv
// Purpose : scoreboard bench for alu_spi_responder; drives serial requests, decodes serial responses.
// Latency : each response checked for value and for its start-bit cycle relative to the request.
// Backpressure: none; the bench paces every bit itself.
module tb_alu_spi_responder;

  localparam int DW = 8;
  localparam int OW = 3;
  localparam int P  = OW + 2 * DW;

  logic clk;
  logic rst;
  logic nss;
  logic mosi;
  logic miso;
  logic busy;

  alu_spi_responder #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_nss   (nss),
    .i_mosi  (mosi),
    .o_miso  (miso),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    int            start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   responses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[2:0];
      3'd6: return a >> b[2:0];
      default: return a;
    endcase
  endfunction

  // Response monitor: samples 1 ns after each rising edge.
  initial begin
    logic          collecting;
    int            nbits;
    int            start_c;
    logic [DW-1:0] got;
    exp_t          e;
    collecting = 1'b0;
    nbits      = 0;
    start_c    = 0;
    got        = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        collecting = 1'b0;
      end else if (!collecting) begin
        if (miso) begin
          collecting = 1'b1;
          nbits      = 0;
          start_c    = cyc;
        end
      end else if (nbits < DW) begin
        if (!busy) begin
          collecting = 1'b0;  // exchange aborted
        end else begin
          got[nbits] = miso;
          nbits++;
        end
      end else begin
        collecting = 1'b0;
        responses++;
        chk("end_miso", {31'd0, miso}, 32'd0);
        chk("end_busy", {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {24'd0, got}, {24'd0, e.res});
          chk("latency", start_c, e.start_cyc);
        end
      end
    end
  end

  // One request. abort_at>=0 raises nss before packet bit abort_at;
  // rst_bit>=0 pulses reset asynchronously while that TX bit is on o_miso.
  task automatic send(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input int abort_at, input int rst_bit);
    logic [P-1:0] pkt;
    exp_t         e;
    int           s;
    pkt = {b, a, op};
    @(negedge clk);
    nss  = 1'b0;
    mosi = 1'b1;
    s    = cyc + 1;
    if (abort_at < 0 && rst_bit < 0) begin
      e.res       = model(op, a, b);
      e.start_cyc = s + P + 1;
      exp_q.push_back(e);
    end
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        nss  = 1'b1;
        mosi = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_miso", {31'd0, miso}, 32'd0);
        return;
      end
      mosi = pkt[i];
    end
    // COMPUTE, TX_START and TX: mosi is noise and must be ignored.
    for (int j = 0; j < DW + 2; j++) begin
      @(negedge clk);
      mosi = 1'($urandom_range(1));
      if (j == rst_bit + 1 && rst_bit >= 0) begin
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        #1;
        rst = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      nss  = 1'b1;
      mosi = 1'b0;
    end
  endtask

  initial begin
    int resp_before;
    rst  = 1'b1;
    nss  = 1'b1;
    mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_miso", {31'd0, miso}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // mosi high while deselected, then selected with mosi low: stays idle.
    mosi = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ign_nss_hi", {31'd0, busy}, 32'd0);
    @(negedge clk);
    nss  = 1'b0;
    mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ign_mosi_lo", {31'd0, busy}, 32'd0);
    chk("ign_mosi_lo_miso", {31'd0, miso}, 32'd0);

    send(3'd0, 8'h7F, 8'h01, -1, -1);   // ADD -> 0x80
    idle(2);
    send(3'd1, 8'h00, 8'h01, -1, -1);   // SUB wrap -> 0xFF
    idle(2);
    send(3'd5, 8'h01, 8'h0B, -1, -1);   // SLL by 3 -> 0x08
    idle(2);
    send(3'd4, 8'h12, 8'h34, 10, -1);   // aborted after 10 bits
    idle(3);
    chk("abort_no_resp", exp_q.size(), 32'd0);
    send(3'd4, 8'hF0, 8'hFF, -1, -1);   // XOR -> 0x0F
    idle(2);

    resp_before = responses;
    send(3'd3, 8'hA5, 8'h5A, -1, 4);    // reset during TX bit 4
    idle(40);
    chk("rst_no_more_resp", responses, resp_before);

    send(3'd2, 8'hAA, 8'h0F, -1, -1);   // back-to-back AND -> 0x0A
    send(3'd2, 8'h3C, 8'hFF, -1, -1);   //                  -> 0x3C
    for (int k = 0; k < 10; k++) begin
      send(3'($urandom_range(7)), 8'($urandom), 8'($urandom), -1, -1);
    end
    send(3'd6, 8'h80, 8'h0F, -1, -1);   // SRL by 7 -> 0x01
    send(3'd7, 8'h5D, 8'h33, -1, -1);   // PASS -> 0x5D
    idle(5);

    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
